voice_sequencer: RTL and testbench
==================================

Name: voice_sequencer

Overview:
Step sequencer that drives the square-wave voice oscillator and its scale ROM.
- Generates the 1 MHz-class tick enable.
- Walks a 16-step note pattern at a fixed tempo.
- Emits note index, gate and pulse width per step.
- Sits between the top level and scale_rom/voice; the top level wires note_out to scale_rom and gates voice output with gate.

Parameters:
TICK_DIV, 25, clk cycles per tick (25 MHz clk -> 1 MHz tick)
STEP_TICKS, 131072, ticks per pattern step
GATE_TICKS, 98304, ticks gate stays high within a step (must be < STEP_TICKS)
PW_BASE, 512, base pulse width (12-bit)
PW_SHIFT, 10, sweep increments once every 2^PW_SHIFT ticks

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  level: 1 = play, 0 = stop at end of current step
pattern_sel  in  1  selects ROM pattern 0/1; sampled only at step 0 start
tick  out  1  one-clk pulse every TICK_DIV clks; feeds voice en
note_out  out  4  scale_rom note index for current step
gate  out  1  1 = voice audible
pulsewidth  out  12  voice pulse width
step_idx  out  4  current step 0..15
bar_strobe  out  1  one-clk pulse when step 15 wraps to step 0
busy  out  1  1 in PLAY or STOPPING

Behaviour:
- Reset (async, active-high): all counters 0; state IDLE; every output 0 except pulsewidth=PW_BASE.
- Tick divider:
  - Free-runs in all states; counts 0..TICK_DIV-1.
  - tick=1 for exactly the clk where count==TICK_DIV-1, so period = TICK_DIV clks.
- States: IDLE, PLAY, STOPPING.
  - IDLE -> PLAY when run=1 at a tick. Step counter, step_idx and sweep are cleared; pattern_sel is latched; entry 0 is loaded.
  - PLAY -> STOPPING when run=0 at a tick. STOPPING -> PLAY if run returns to 1 before step end.
  - STOPPING -> IDLE at the step boundary; gate is forced 0 there.
- Step timing, PLAY/STOPPING, all updates on tick clks only:
  - tick_in_step counts 0..STEP_TICKS-1.
  - At wrap, step_idx = (step_idx+1) mod 16.
  - When wrapping 15->0: bar_strobe pulses on that clk, and pattern_sel is re-latched.
- Pattern entry, 6 bits: {rest, accent, note[3:0]}.
  - ROM holds 2 patterns x 16 entries; the ROM is combinational.
  - Outputs are registered, so note_out and gate change on the clk after the step boundary tick (1-clk latency).
- Gate:
  - gate = !rest && tick_in_step < GATE_TICKS.
  - gate=0 in IDLE.
  - A rest step holds the previous note_out.
- Pulse width:
  - 9-bit sweep counter increments every 2^PW_SHIFT ticks in PLAY/STOPPING and wraps 511->0.
  - pulsewidth = PW_BASE + {3'b0,sweep} + (accent ? 1024 : 0), 12-bit, truncating.
  - Frozen, not cleared, in IDLE.
- Simultaneous events: run falling on the same tick as a step boundary -> the new step is played and STOPPING is entered; STOPPING ends at the next boundary.
- Reset mid-step: immediate return to IDLE, gate drops asynchronously.

Decomposition:
- Shared package audio_pkg holds:
  - state enum (IDLE/PLAY/STOPPING);
  - the pattern entry struct {rest, accent, note};
  - the two 16-entry pattern constant arrays;
  - the accent offset constant 1024.
- One sub-module: tick_gen (TICK_DIV divider, async reset, tick output), reusable by other audio blocks.

Test Plan (all with TICK_DIV=4, STEP_TICKS=8, GATE_TICKS=6, PW_SHIFT=2):
- Reset then idle 100 clks:
  - tick pulses every 4 clks;
  - gate=0, step_idx=0, pulsewidth=512, busy=0.
- run=1 with pattern 0, entry0={0,0,5}:
  - note_out=5 one clk after the start tick;
  - gate high for 24 clks then low for 8;
  - step_idx reaches 1 at clk 32 after start.
- Play 16 steps:
  - bar_strobe single pulse at the 15->0 wrap;
  - toggling pattern_sel mid-bar takes effect only at step 0.
- Rest/accent:
  - rest entry -> gate stays 0 all step, note_out unchanged;
  - accent entry with sweep=3 -> pulsewidth=512+3+1024=1539.
- run=0 at tick 2 of a step:
  - step completes with busy=1;
  - IDLE at the boundary, gate=0, note_out held.
- Assert reset mid-gate:
  - gate and busy drop without waiting for a clk edge;
  - after release, state is IDLE and counters are 0.

Source files
------------

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the audio voice blocks.
//   seq_state_t   : sequencer state (IDLE / PLAY / STOPPING)
//   pat_entry_t   : one pattern step {rest, accent, note[3:0]}
//   PATTERN0/1    : the two 16-step note patterns (index 0 = first step)
//   ACCENT_OFFSET : pulse-width boost applied on accented steps
//   rom_entry()   : combinational pattern ROM lookup
// -----------------------------------------------------------------------------
package audio_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PLAY     = 2'd1,
      STOPPING = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic       rest;
      logic       accent;
      logic [3:0] note;
   } pat_entry_t;

   localparam int          PAT_LEN       = 16;
   localparam logic [11:0] ACCENT_OFFSET = 12'd1024;

   // Entries are {rest, accent, note[3:0]}.
   localparam logic [5:0] PATTERN0 [PAT_LEN] = '{
      6'h05, 6'h17, 6'h20, 6'h09, 6'h1C, 6'h03, 6'h20, 6'h0A,
      6'h15, 6'h02, 6'h0E, 6'h30, 6'h08, 6'h11, 6'h06, 6'h0F
   };

   localparam logic [5:0] PATTERN1 [PAT_LEN] = '{
      6'h10, 6'h04, 6'h0B, 6'h20, 6'h0D, 6'h12, 6'h07, 6'h20,
      6'h09, 6'h13, 6'h01, 6'h0C, 6'h20, 6'h06, 6'h1F, 6'h04
   };

   function automatic pat_entry_t rom_entry(input logic sel, input logic [3:0] idx);
      rom_entry = sel ? pat_entry_t'(PATTERN1[idx]) : pat_entry_t'(PATTERN0[idx]);
   endfunction

endpackage

// File: rtl/voice_sequencer_if.sv
// -----------------------------------------------------------------------------
// voice_sequencer_if
// Control/output bundle of the step sequencer.
//   run, pattern_sel            : driven by the top level (master)
//   tick, note_out, gate,
//   pulsewidth, step_idx,
//   bar_strobe, busy            : driven by the sequencer (slave)
// -----------------------------------------------------------------------------
interface voice_sequencer_if;

   logic        run;
   logic        pattern_sel;
   logic        tick;
   logic [3:0]  note_out;
   logic        gate;
   logic [11:0] pulsewidth;
   logic [3:0]  step_idx;
   logic        bar_strobe;
   logic        busy;

   modport master (
      output run, pattern_sel,
      input  tick, note_out, gate, pulsewidth, step_idx, bar_strobe, busy
   );

   modport slave (
      input  run, pattern_sel,
      output tick, note_out, gate, pulsewidth, step_idx, bar_strobe, busy
   );

endinterface

// File: rtl/voice_sequencer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running clock divider producing a one-clk enable every TICK_DIV clks.
//   clk    : system clock
//   reset  : asynchronous, active-high reset (counter to 0)
//   o_tick : high for the single clk where the count equals TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int TICK_DIV = 25
) (
   input  logic clk,
   input  logic reset,
   output logic o_tick
);

   localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/voice_sequencer.sv
// -----------------------------------------------------------------------------
// voice_sequencer
// 16-step note sequencer for the square-wave voice.
//   clk, reset        : system clock, asynchronous active-high reset
//   bus.run           : 1 = play, 0 = stop at the end of the current step
//   bus.pattern_sel   : pattern choice, latched at start and at each bar wrap
//   bus.tick          : one-clk tick enable (also the voice enable)
//   bus.note_out      : scale ROM note index for the current step
//   bus.gate          : voice audible
//   bus.pulsewidth    : PW_BASE + sweep (+ accent offset), 12-bit wrapping
//   bus.step_idx      : current step 0..15
//   bus.bar_strobe    : one-clk pulse when step 15 wraps to step 0
//   bus.busy          : high in PLAY or STOPPING
// All sequencing happens on tick clks; outputs are registered, so they follow
// the deciding tick by one clk.
// -----------------------------------------------------------------------------
module voice_sequencer
   import audio_pkg::*;
#(
   parameter int          TICK_DIV   = 25,
   parameter int          STEP_TICKS = 131072,
   parameter int          GATE_TICKS = 98304,
   parameter logic [11:0] PW_BASE    = 12'd512,
   parameter int          PW_SHIFT   = 10
) (
   input  logic             clk,
   input  logic             reset,
   voice_sequencer_if.slave bus
);

   localparam int               TIS_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam logic [TIS_W-1:0] TIS_LAST = TIS_W'(STEP_TICKS - 1);
   localparam logic [TIS_W-1:0] GATE_LIM = TIS_W'(GATE_TICKS);
   localparam int               SWD_W    = (PW_SHIFT > 0) ? PW_SHIFT : 1;
   localparam logic [SWD_W-1:0] SWD_LAST = SWD_W'((2 ** PW_SHIFT) - 1);

   // Pulse width is a plain 12-bit wrapping sum; overflow is not saturated.
   function automatic logic [11:0] pw_wrap(input logic [8:0] sweep, input logic accent);
      pw_wrap = PW_BASE + {3'b000, sweep} + (accent ? ACCENT_OFFSET : 12'd0);
   endfunction

   seq_state_t       r_state, w_state_nxt;
   logic [TIS_W-1:0] r_tis, w_tis_nxt;
   logic [3:0]       r_step, w_step_nxt;
   logic             r_pat, w_pat_nxt;
   logic [SWD_W-1:0] r_swdiv, w_swdiv_nxt;
   logic [8:0]       r_sweep, w_sweep_nxt;
   pat_entry_t       r_entry, w_entry_nxt, w_rom_entry;
   logic [3:0]       r_note;
   logic             r_gate;
   logic [11:0]      r_pw;
   logic             r_bar;

   logic w_tick, w_step_end, w_bar_wrap, w_start, w_active, w_load;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .o_tick (w_tick)
   );

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (w_tick) begin
         case (r_state)
            IDLE:     if (bus.run)  w_state_nxt = PLAY;
            PLAY:     if (!bus.run) w_state_nxt = STOPPING;
            STOPPING: begin
               if (bus.run)         w_state_nxt = PLAY;
               else if (w_step_end) w_state_nxt = IDLE;
            end
            default:                w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Counter and pattern advance: candidate values for the next tick
   always_comb begin
      w_step_end = (r_tis == TIS_LAST);
      w_bar_wrap = w_step_end && (r_step == 4'd15);
      w_start    = w_tick && (r_state == IDLE) && bus.run;
      w_active   = w_tick && (r_state != IDLE);
      if (w_start) begin
         w_tis_nxt   = '0;
         w_step_nxt  = '0;
         w_pat_nxt   = bus.pattern_sel;
         w_swdiv_nxt = '0;
         w_sweep_nxt = '0;
      end else begin
         w_tis_nxt   = w_step_end ? '0 : r_tis + TIS_W'(1);
         w_step_nxt  = w_step_end ? r_step + 4'd1 : r_step;
         // pattern_sel only takes effect when a new bar begins
         w_pat_nxt   = w_bar_wrap ? bus.pattern_sel : r_pat;
         w_swdiv_nxt = (r_swdiv == SWD_LAST) ? '0 : r_swdiv + SWD_W'(1);
         w_sweep_nxt = (r_swdiv == SWD_LAST) ? r_sweep + 9'd1 : r_sweep;
      end
      w_load      = w_start || (w_active && w_step_end);
      w_rom_entry = rom_entry(w_pat_nxt, w_step_nxt);
      w_entry_nxt = w_load ? w_rom_entry : r_entry;
   end

   // Registered counters and outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tis   <= '0;
         r_step  <= '0;
         r_pat   <= 1'b0;
         r_swdiv <= '0;
         r_sweep <= '0;
         r_entry <= '0;
         r_note  <= '0;
         r_gate  <= 1'b0;
         r_pw    <= PW_BASE;
         r_bar   <= 1'b0;
      end else begin
         r_bar <= 1'b0;
         if (w_start || w_active) begin
            r_tis   <= w_tis_nxt;
            r_step  <= w_step_nxt;
            r_pat   <= w_pat_nxt;
            r_swdiv <= w_swdiv_nxt;
            r_sweep <= w_sweep_nxt;
            r_entry <= w_entry_nxt;
            r_bar   <= w_active && w_bar_wrap;
            if (w_state_nxt == IDLE) begin
               // Stopping at the boundary: silence, hold note and pulse width
               r_gate <= 1'b0;
            end else begin
               r_gate <= !w_entry_nxt.rest && (w_tis_nxt < GATE_LIM);
               // A rest keeps the previous note so the oscillator pitch is stable
               if (!w_entry_nxt.rest) r_note <= w_entry_nxt.note;
               r_pw   <= pw_wrap(w_sweep_nxt, w_entry_nxt.accent);
            end
         end
      end
   end

   assign bus.tick       = w_tick;
   assign bus.note_out   = r_note;
   assign bus.gate       = r_gate;
   assign bus.pulsewidth = r_pw;
   assign bus.step_idx   = r_step;
   assign bus.bar_strobe = r_bar;
   assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_voice_sequencer.sv
// -----------------------------------------------------------------------------
// tb_voice_sequencer
// Bench for voice_sequencer with TICK_DIV=4, STEP_TICKS=8, GATE_TICKS=6,
// PW_SHIFT=2. A behavioural model derives every output from the number of
// ticks played since the start (step, tick-in-step and sweep are plain
// divisions of that count); a compare process checks it every clk, and a
// directed/random stimulus sequence adds literal checkpoints.
// -----------------------------------------------------------------------------
module tb_voice_sequencer;

   localparam int TD   = 4;
   localparam int ST   = 8;
   localparam int GT   = 6;
   localparam int PS   = 2;
   localparam int BASE = 512;

   localparam logic [5:0] TB_PAT0 [16] = '{
      6'h05, 6'h17, 6'h20, 6'h09, 6'h1C, 6'h03, 6'h20, 6'h0A,
      6'h15, 6'h02, 6'h0E, 6'h30, 6'h08, 6'h11, 6'h06, 6'h0F
   };
   localparam logic [5:0] TB_PAT1 [16] = '{
      6'h10, 6'h04, 6'h0B, 6'h20, 6'h0D, 6'h12, 6'h07, 6'h20,
      6'h09, 6'h13, 6'h01, 6'h0C, 6'h20, 6'h06, 6'h1F, 6'h04
   };

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   voice_sequencer_if bus ();

   voice_sequencer #(
      .TICK_DIV   (TD),
      .STEP_TICKS (ST),
      .GATE_TICKS (GT),
      .PW_BASE    (12'd512),
      .PW_SHIFT   (PS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          k     = 0;   // clks since reset release
   int          n     = 0;   // ticks played since start
   int          mst   = 0;   // 0 idle, 1 play, 2 stopping
   bit          m_pat = 1'b0;
   logic [3:0]  e_note = 4'd0;
   logic [3:0]  e_step = 4'd0;
   logic        e_gate = 1'b0;
   logic        e_bar  = 1'b0;
   logic [11:0] e_pw   = 12'd512;

   task automatic emit();
      logic [5:0] ent;
      int tis, stp, sw;
      tis = n % ST;
      stp = (n / ST) % 16;
      sw  = (n >> PS) % 512;
      ent = m_pat ? TB_PAT1[stp] : TB_PAT0[stp];
      if (!ent[5]) e_note = ent[3:0];
      e_gate = !ent[5] && (tis < GT);
      e_pw   = 12'((BASE + sw + (ent[4] ? 1024 : 0)) % 4096);
   endtask

   always @(posedge clk or posedge reset) begin : model
      bit tk;
      bit bnd;
      int stp;
      if (reset) begin
         k = 0; n = 0; mst = 0; m_pat = 1'b0;
         e_note = 4'd0; e_step = 4'd0; e_gate = 1'b0; e_bar = 1'b0; e_pw = 12'd512;
      end else begin
         tk = ((k % TD) == TD - 1);
         k++;
         e_bar = 1'b0;
         if (tk) begin
            if (mst == 0) begin
               if (bus.run) begin
                  mst = 1; n = 0; m_pat = bus.pattern_sel; e_step = 4'd0;
                  emit();
               end
            end else begin
               n++;
               bnd = ((n % ST) == 0);
               stp = (n / ST) % 16;
               if (bnd && stp == 0) begin
                  e_bar = 1'b1;
                  m_pat = bus.pattern_sel;
               end
               if (mst == 1) begin
                  if (!bus.run) mst = 2;
               end else if (bus.run) mst = 1;
               else if (bnd) mst = 0;
               e_step = 4'(stp);
               if (mst == 0) e_gate = 1'b0;
               else emit();
            end
         end
      end
   end

   // ---------------- per-clk compare ----------------
   always @(negedge clk) begin
      chk("tick",       int'(bus.tick),       int'((k % TD) == TD - 1));
      chk("note_out",   int'(bus.note_out),   int'(e_note));
      chk("gate",       int'(bus.gate),       int'(e_gate));
      chk("pulsewidth", int'(bus.pulsewidth), int'(e_pw));
      chk("step_idx",   int'(bus.step_idx),   int'(e_step));
      chk("bar_strobe", int'(bus.bar_strobe), int'(e_bar));
      chk("busy",       int'(bus.busy),       int'(mst != 0));
   end

   task automatic wait_edge(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: run did not complete (total=%0d bad=%0d)", total, bad);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int e0;
      int ticks;
      int ghigh;
      int bars;
      int bar_at;
      bit seen;

      reset = 1'b1;
      bus.run = 1'b0;
      bus.pattern_sel = 1'b0;
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;

      // Idle: tick period and reset values
      ticks = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.tick) ticks++;
      end
      chk("idle_tick_count", ticks, 25);
      chk("idle_gate", int'(bus.gate), 0);
      chk("idle_step", int'(bus.step_idx), 0);
      chk("idle_pw", int'(bus.pulsewidth), 512);
      chk("idle_busy", int'(bus.busy), 0);

      // Start pattern 0
      bus.run = 1'b1;
      bus.pattern_sel = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         if (bus.tick) seen = 1'b1;
         else @(negedge clk);
      end
      chk("start_tick_found", int'(seen), 1);
      e0 = cyc + 1;
      wait_edge(e0);
      chk("start_note", int'(bus.note_out), 5);
      chk("model_start_note", int'(e_note), 5);
      chk("start_gate", int'(bus.gate), 1);
      chk("start_busy", int'(bus.busy), 1);

      ghigh = 0;
      for (int i = 0; i < 32; i++) begin
         wait_edge(e0 + i);
         if (bus.gate) ghigh++;
      end
      chk("gate_high_clks", ghigh, 24);
      chk("step_before_32", int'(bus.step_idx), 0);
      wait_edge(e0 + 32);
      chk("step_at_32", int'(bus.step_idx), 1);
      chk("step1_note", int'(bus.note_out), 7);

      // Accented step 1 with sweep 3
      wait_edge(e0 + 48);
      chk("accent_pw", int'(bus.pulsewidth), 1539);
      chk("model_accent_pw", int'(e_pw), 1539);

      // Step 2 is a rest
      wait_edge(e0 + 64);
      chk("rest_note_held", int'(bus.note_out), 7);
      chk("rest_gate_start", int'(bus.gate), 0);
      wait_edge(e0 + 88);
      chk("rest_gate_mid", int'(bus.gate), 0);

      // Pattern select changed mid-bar must wait for step 0
      wait_edge(e0 + 161);
      bus.pattern_sel = 1'b1;
      wait_edge(e0 + 196);
      chk("midbar_sel_note", int'(bus.note_out), 3);
      chk("midbar_sel_gate", int'(bus.gate), 0);

      bars = 0;
      bar_at = -1;
      for (int i = 200; i <= 520; i++) begin
         wait_edge(e0 + i);
         if (bus.bar_strobe) begin
            bars++;
            if (bar_at < 0) bar_at = i;
         end
      end
      chk("bar_pulse_count", bars, 1);
      chk("bar_pulse_clk", bar_at, 512);
      chk("bar2_note", int'(bus.note_out), 0);
      chk("bar2_pw", int'(bus.pulsewidth), 1568);
      chk("bar2_step", int'(bus.step_idx), 0);

      // Stop requested on tick 2 of absolute step 18
      wait_edge(e0 + 581);
      bus.run = 1'b0;
      wait_edge(e0 + 604);
      chk("stopping_busy", int'(bus.busy), 1);
      wait_edge(e0 + 608);
      chk("stop_busy", int'(bus.busy), 0);
      chk("stop_gate", int'(bus.gate), 0);
      chk("stop_note_held", int'(bus.note_out), 11);
      wait_edge(e0 + 640);
      chk("idle_after_stop_busy", int'(bus.busy), 0);
      chk("idle_after_stop_note", int'(bus.note_out), 11);

      // Randomised run / pattern activity
      bus.run = 1'b1;
      repeat (4000) begin
         @(negedge clk);
         if ($urandom_range(0, 149) == 0) bus.run = ~bus.run;
         if ($urandom_range(0, 59) == 0)  bus.pattern_sel = ~bus.pattern_sel;
      end

      // Reset while the gate is open
      bus.run = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (bus.gate && bus.busy) seen = 1'b1;
      end
      chk("gate_open_before_reset", int'(seen), 1);
      #1 reset = 1'b1;
      #1;
      chk("async_reset_gate", int'(bus.gate), 0);
      chk("async_reset_busy", int'(bus.busy), 0);
      chk("async_reset_pw", int'(bus.pulsewidth), 512);
      chk("async_reset_step", int'(bus.step_idx), 0);
      bus.run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_reset_busy", int'(bus.busy), 0);
      chk("post_reset_step", int'(bus.step_idx), 0);
      chk("post_reset_note", int'(bus.note_out), 0);
      chk("post_reset_gate", int'(bus.gate), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
